remote_cmd_tx: RTL and testbench

- Ground-station end of the quadcopter command link.
- Takes a command request (8-bit opcode plus 16-bit data) and serializes it as a 3-byte frame through an external UART transmitter. Byte order: cmd, data[15:8], data[7:0].
- After the frame, waits for the single response byte the airframe's command processor returns: 0xA5 for positive acknowledge.
- Times out if no response arrives.
- Sits between the remote/test-harness logic and a byte-level UART tx/rx pair.

---
 rtl/remote_cmd_tx.sv | 101 ++++++++++
 tb/tb_remote_cmd_tx.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/remote_cmd_tx.sv
// Ground-station command link: frames opcode + 16-bit payload into three UART bytes,
// then waits for the airframe's single response byte or a timeout.
module remote_cmd_tx #(
  parameter bit FAST_SIM    = 1'b0,
  parameter int TIMER_WIDTH = (FAST_SIM ? 9 : 26)
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       snd_cmd,
  input  logic [7:0] cmd,
  input  logic [15:0] data,
  output logic [7:0] tx_data,
  output logic       trmt,
  input  logic       tx_done,
  input  logic       rx_rdy,
  input  logic [7:0] rx_data,
  output logic       clr_rx_rdy,
  output logic       busy,
  output logic       cmd_cmplt,
  output logic [7:0] resp,
  output logic       resp_rdy,
  output logic       resp_timeout
);

  typedef enum logic [2:0] {IDLE, TX_CMD, TX_HI, TX_LO, WAIT_RESP} state_t;

  state_t                 state;
  logic [15:0]            data_sh;
  logic [TIMER_WIDTH-1:0] timer;

  assign busy = (state != IDLE);

  // Any byte the receiver holds is consumed immediately; only WAIT_RESP keeps it.
  assign clr_rx_rdy = rx_rdy & ~rst;

  // tx_data doubles as the opcode shadow: it is loaded once at launch and not
  // touched again until the opcode byte has been sent.
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      data_sh      <= '0;
      timer        <= '0;
      tx_data      <= '0;
      trmt         <= 1'b0;
      cmd_cmplt    <= 1'b0;
      resp         <= '0;
      resp_rdy     <= 1'b0;
      resp_timeout <= 1'b0;
    end else begin
      trmt      <= 1'b0;
      cmd_cmplt <= 1'b0;
      case (state)
        IDLE: begin
          if (snd_cmd) begin
            data_sh      <= data;
            tx_data      <= cmd;
            trmt         <= 1'b1;
            resp_rdy     <= 1'b0;
            resp_timeout <= 1'b0;
            state        <= TX_CMD;
          end
        end
        TX_CMD: begin
          if (tx_done) begin
            tx_data <= data_sh[15:8];
            trmt    <= 1'b1;
            state   <= TX_HI;
          end
        end
        TX_HI: begin
          if (tx_done) begin
            tx_data <= data_sh[7:0];
            trmt    <= 1'b1;
            state   <= TX_LO;
          end
        end
        TX_LO: begin
          if (tx_done) begin
            cmd_cmplt <= 1'b1;
            timer     <= '0;
            state     <= WAIT_RESP;
          end
        end
        WAIT_RESP: begin
          // A response arriving on the timer-full cycle takes priority over the timeout.
          timer <= timer + 1'b1;
          if (rx_rdy) begin
            resp     <= rx_data;
            resp_rdy <= 1'b1;
            state    <= IDLE;
          end else if (timer == '1) begin
            resp_timeout <= 1'b1;
            state        <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_remote_cmd_tx.sv
// Directed bench for remote_cmd_tx: a UART model answers each trmt with tx_done
// 20 cycles later, and a scoreboard queue holds the bytes each frame must emit.
module tb_remote_cmd_tx;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        snd_cmd = 1'b0;
  logic [7:0]  cmd = '0;
  logic [15:0] data = '0;
  logic [7:0]  tx_data;
  logic        trmt;
  logic        tx_done = 1'b0;
  logic        rx_rdy = 1'b0;
  logic [7:0]  rx_data = '0;
  logic        clr_rx_rdy;
  logic        busy;
  logic        cmd_cmplt;
  logic [7:0]  resp;
  logic        resp_rdy;
  logic        resp_timeout;

  int checks = 0;
  int failures = 0;
  logic [7:0] exp_q[$];
  logic [7:0] exp_byte;
  int trmt_total = 0;
  int cmplt_total = 0;
  int cyc = 0;
  int countdown = 0;
  int frame_byte = 0;
  bit last_flag = 1'b0;
  int last_done_cyc = -10;

  remote_cmd_tx #(.FAST_SIM(1'b1)) dut (
    .clk(clk), .rst(rst), .snd_cmd(snd_cmd), .cmd(cmd), .data(data),
    .tx_data(tx_data), .trmt(trmt), .tx_done(tx_done), .rx_rdy(rx_rdy),
    .rx_data(rx_data), .clr_rx_rdy(clr_rx_rdy), .busy(busy), .cmd_cmplt(cmd_cmplt),
    .resp(resp), .resp_rdy(resp_rdy), .resp_timeout(resp_timeout)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // UART transmitter model plus scoreboard pop on every trmt pulse.
  always @(negedge clk) begin
    tx_done = 1'b0;
    if (rst) begin
      countdown  = 0;
      frame_byte = 0;
      last_flag  = 1'b0;
    end else begin
      if (countdown > 0) begin
        countdown--;
        if (countdown == 0) begin
          tx_done = 1'b1;
          if (last_flag) begin
            last_done_cyc = cyc;
            last_flag = 1'b0;
          end
        end
      end
      if (trmt) begin
        trmt_total++;
        checks++;
        assert (exp_q.size() != 0) else begin
          failures++;
          $error("[TB] FAIL unexpected_trmt observed=%02h expected=no_pulse", tx_data);
        end
        if (exp_q.size() != 0) begin
          exp_byte = exp_q.pop_front();
          checks++;
          assert (tx_data === exp_byte) else begin
            failures++;
            $error("[TB] FAIL tx_byte observed=%02h expected=%02h", tx_data, exp_byte);
          end
        end
        countdown = 20;
        if (frame_byte == 2) last_flag = 1'b1;
        frame_byte = (frame_byte + 1) % 3;
      end
    end
    if (cmd_cmplt) begin
      cmplt_total++;
      checks++;
      assert (cyc === last_done_cyc + 1) else begin
        failures++;
        $error("[TB] FAIL cmplt_timing observed_cyc=%0d expected_cyc=%0d", cyc, last_done_cyc + 1);
      end
    end
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog observed=time_limit expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Launch a frame and queue the three bytes it must produce; afterwards scramble
  // cmd/data so any use of the live inputs shows up as a wrong byte.
  task automatic applyStimulus(input logic [7:0] c, input logic [15:0] d);
    cmd = c;
    data = d;
    snd_cmd = 1'b1;
    exp_q.push_back(c);
    exp_q.push_back(d[15:8]);
    exp_q.push_back(d[7:0]);
    step();
    snd_cmd = 1'b0;
    cmd = 8'hEE;
    data = 16'hDEAD;
    checkOutput("busy_after_launch", busy, 1);
  endtask

  task automatic waitTrmt();
    int n = 0;
    while (n < 100) begin
      step();
      n++;
      if (trmt) break;
    end
    checkOutput("trmt_seen", trmt, 1);
  endtask

  task automatic waitCmplt();
    int n = 0;
    while (!cmd_cmplt && n < 300) begin
      step();
      n++;
    end
    checkOutput("cmplt_seen", cmd_cmplt, 1);
  endtask

  task automatic respond(input logic [7:0] b);
    rx_rdy = 1'b1;
    rx_data = b;
    #1;
    checkOutput("clr_rx_rdy", clr_rx_rdy, 1);
    step();
    rx_rdy = 1'b0;
  endtask

  initial begin
    int t0;
    int c0;
    int n;

    $display("[TB] start");
    step();
    step();
    rst = 1'b0;
    checkOutput("rst_busy", busy, 0);
    checkOutput("rst_trmt", trmt, 0);
    checkOutput("rst_tx_data", tx_data, 0);
    checkOutput("rst_resp", resp, 0);
    checkOutput("rst_resp_rdy", resp_rdy, 0);
    checkOutput("rst_timeout", resp_timeout, 0);
    checkOutput("rst_cmplt", cmd_cmplt, 0);
    checkOutput("rst_clr", clr_rx_rdy, 0);

    // Basic frame with positive acknowledge
    t0 = trmt_total;
    applyStimulus(8'h02, 16'h1234);
    waitCmplt();
    repeat (3) step();
    checkOutput("wait_busy", busy, 1);
    respond(8'hA5);
    checkOutput("basic_resp", resp, 8'hA5);
    checkOutput("basic_resp_rdy", resp_rdy, 1);
    checkOutput("basic_busy", busy, 0);
    checkOutput("basic_trmts", trmt_total - t0, 3);
    checkOutput("basic_q_empty", exp_q.size(), 0);

    // Timeout: flag registers at the edge closing the timer-full cycle
    applyStimulus(8'h06, 16'h0000);
    checkOutput("launch_clears_rdy", resp_rdy, 0);
    waitCmplt();
    n = 0;
    while (!resp_timeout && n < 600) begin
      step();
      n++;
    end
    checkOutput("timeout_latency", n, 512);
    checkOutput("timeout_flag", resp_timeout, 1);
    checkOutput("timeout_resp_rdy", resp_rdy, 0);
    checkOutput("timeout_resp_kept", resp, 8'hA5);
    checkOutput("timeout_busy", busy, 0);
    step();

    // Busy rejection in TX_HI; non-A5 response; snd_cmd on return cycle ignored
    t0 = trmt_total;
    applyStimulus(8'h04, 16'hCAFE);
    checkOutput("launch_clears_timeout", resp_timeout, 0);
    waitTrmt();
    step();
    cmd = 8'h05;
    data = 16'h00FF;
    snd_cmd = 1'b1;
    step();
    snd_cmd = 1'b0;
    cmd = 8'hEE;
    data = 16'hDEAD;
    waitCmplt();
    step();
    snd_cmd = 1'b1;
    cmd = 8'h05;
    data = 16'h00FF;
    respond(8'h3C);
    snd_cmd = 1'b0;
    checkOutput("return_snd_ignored", busy, 0);
    checkOutput("other_resp", resp, 8'h3C);
    checkOutput("other_resp_rdy", resp_rdy, 1);
    repeat (30) step();
    checkOutput("reject_trmts", trmt_total - t0, 3);
    checkOutput("reject_q_empty", exp_q.size(), 0);

    // Stale byte during TX_CMD is discarded
    applyStimulus(8'h03, 16'hBEEF);
    step();
    respond(8'h55);
    checkOutput("stale_resp_kept", resp, 8'h3C);
    checkOutput("stale_resp_rdy", resp_rdy, 0);
    checkOutput("stale_busy", busy, 1);
    waitCmplt();
    step();
    respond(8'hA5);
    checkOutput("stale_then_resp", resp, 8'hA5);
    checkOutput("stale_then_rdy", resp_rdy, 1);

    // Response arrives on the timer-full cycle
    applyStimulus(8'h07, 16'h0001);
    waitCmplt();
    for (int i = 1; i <= 511; i++) step();
    checkOutput("full_no_timeout_yet", resp_timeout, 0);
    respond(8'h5A);
    checkOutput("simul_resp_rdy", resp_rdy, 1);
    checkOutput("simul_timeout", resp_timeout, 0);
    checkOutput("simul_resp", resp, 8'h5A);
    checkOutput("simul_busy", busy, 0);

    // Reset during TX_HI aborts the frame
    applyStimulus(8'h08, 16'h4321);
    waitTrmt();
    repeat (3) step();
    exp_q.delete();
    t0 = trmt_total;
    c0 = cmplt_total;
    rst = 1'b1;
    step();
    checkOutput("mid_rst_busy", busy, 0);
    checkOutput("mid_rst_trmt", trmt, 0);
    checkOutput("mid_rst_tx_data", tx_data, 0);
    checkOutput("mid_rst_resp", resp, 0);
    checkOutput("mid_rst_rdy", resp_rdy, 0);
    checkOutput("mid_rst_timeout", resp_timeout, 0);
    checkOutput("mid_rst_cmplt", cmd_cmplt, 0);
    step();
    rst = 1'b0;
    repeat (50) step();
    checkOutput("abort_no_trmt", trmt_total - t0, 0);
    checkOutput("abort_no_cmplt", cmplt_total - c0, 0);

    // Clean frame after the abort
    t0 = trmt_total;
    applyStimulus(8'h02, 16'h0A0B);
    waitCmplt();
    step();
    respond(8'hA5);
    checkOutput("post_rst_resp", resp, 8'hA5);
    checkOutput("post_rst_rdy", resp_rdy, 1);
    checkOutput("post_rst_trmts", trmt_total - t0, 3);
    checkOutput("post_rst_q_empty", exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
